// File: rtl/csa_accumulator_if.sv
// Operand stream, result stream and burst control for csa_accumulator.
// master is the operand source / result consumer side; slave is the accumulator.
interface csa_accumulator_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   localparam int ACC_W = WIDTH + CNT_W;

   logic             start;
   logic [CNT_W-1:0] num_ops;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] result;
   logic             busy;

   modport master (
      output start, num_ops, in_valid, in_data, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  start, num_ops, in_valid, in_data, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/csa_accumulator.sv
// Sums a burst of unsigned operands in carry-save form, then resolves the
// redundant sum/carry pair with a single carry-propagate add.
module csa_accumulator #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   csa_accumulator_if.slave    bus
);
   localparam int ACC_W = WIDTH + CNT_W;

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [ACC_W-1:0] s_q, s_d;
   logic [ACC_W-1:0] c_q, c_d;
   logic [ACC_W-1:0] result_q, result_d;

   logic [ACC_W-1:0] x;
   logic [ACC_W-1:0] fa_sum;
   logic [ACC_W-2:0] fa_maj;
   logic             in_fire;

   assign x       = {{CNT_W{1'b0}}, bus.in_data};
   assign in_fire = bus.in_valid && (state_q == ACCUM);

   genvar gi;
   generate
      for (gi = 0; gi < ACC_W; gi++) begin : g_fa_sum
         assign fa_sum[gi] = s_q[gi] ^ c_q[gi] ^ x[gi];
      end
      // The top majority bit is never needed: the worst-case sum fits in ACC_W bits.
      for (gi = 0; gi < ACC_W - 1; gi++) begin : g_fa_maj
         assign fa_maj[gi] = (s_q[gi] & c_q[gi]) | (s_q[gi] & x[gi]) | (c_q[gi] & x[gi]);
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      s_d         = s_q;
      c_d         = c_q;
      result_d    = result_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               s_d         = '0;
               c_d         = '0;
               remaining_d = bus.num_ops;
               state_d     = (bus.num_ops != '0) ? ACCUM : RESOLVE;
            end
         end
         ACCUM: begin
            if (in_fire) begin
               s_d         = fa_sum;
               c_d         = {fa_maj, 1'b0};
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = RESOLVE;
               end
            end
         end
         RESOLVE: begin
            result_d = s_q + c_q;
            state_d  = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         s_q         <= '0;
         c_q         <= '0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         s_q         <= s_d;
         c_q         <= c_d;
         result_q    <= result_d;
      end
   end

   // Outputs are pure state decodes; nothing here depends on in_valid/out_ready.
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.result    = result_q;
endmodule
